// File: rtl/adc_sched_pkg.sv
// Shared types and width/consistency helpers for the ADC frame scheduler.
package adc_sched_pkg;

  typedef enum logic {StIdle, StFill} buf_state_e;

  // Bits needed to hold values 0..n-1. Never returns less than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit sched_params_ok(input int unsigned fft_len, input int unsigned hop,
                                         input int unsigned num_fft, input int unsigned frames,
                                         input int unsigned block_len);
    bit ok;
    ok = (fft_len >= 2) && ((fft_len & (fft_len - 1)) == 0);
    ok = ok && (hop > 0) && ((fft_len % hop) == 0);
    ok = ok && (num_fft >= fft_len / hop);
    ok = ok && (frames >= 1);
    ok = ok && (block_len >= (frames - 1) * hop + fft_len);
    return ok;
  endfunction

endpackage

// File: rtl/fft_buffer_writer.sv
// One FFT input buffer: accepts or drops a window on its start strobe, then
// streams FFT_LEN addresses, one per valid sample.
module fft_buffer_writer
  import adc_sched_pkg::*;
#(
  parameter int unsigned FFT_LEN = 1024,
  parameter int unsigned ADDR_W  = cnt_width(FFT_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_start,
  input  logic              i_ready,
  output logic              o_write_active,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_frame_start,
  output logic              o_frame_done,
  output logic              o_overrun
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FFT_LEN - 1);

  buf_state_e        r_state, w_state_d;
  logic [ADDR_W-1:0] r_cnt, w_cnt_d;
  logic              w_active_d, w_start_d, w_done_d, w_ovr_d;
  logic [ADDR_W-1:0] w_addr_d;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_active_d = 1'b0;
    w_addr_d   = '0;
    w_start_d  = 1'b0;
    w_done_d   = 1'b0;
    w_ovr_d    = o_overrun;
    if (i_valid) begin
      // A start that finds the buffer busy or not ready loses the whole window.
      if (i_start && ((r_state == StFill) || !i_ready)) begin
        w_ovr_d = 1'b1;
      end
      unique case (r_state)
        StFill: begin
          w_active_d = 1'b1;
          w_addr_d   = r_cnt;
          w_cnt_d    = ADDR_W'(r_cnt + 1'b1);
          if (r_cnt == LastAddr) begin
            w_done_d  = 1'b1;
            w_cnt_d   = '0;
            w_state_d = StIdle;
          end
        end
        StIdle: begin
          if (i_start && i_ready) begin
            w_active_d = 1'b1;
            w_start_d  = 1'b1;
            w_cnt_d    = ADDR_W'(1);
            w_state_d  = StFill;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      o_write_active <= 1'b0;
      o_addr         <= '0;
      o_frame_start  <= 1'b0;
      o_frame_done   <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      o_write_active <= w_active_d;
      o_addr         <= w_addr_d;
      o_frame_start  <= w_start_d;
      o_frame_done   <= w_done_d;
      o_overrun      <= w_ovr_d;
    end
  end

endmodule

// File: rtl/adc_frame_scheduler.sv
// Steers each ADC sample into up to NUM_FFT overlapping FFT windows following a
// block / hop / frames-per-block schedule.
module adc_frame_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned DATA_W           = 12,
  parameter int unsigned FFT_LEN          = 1024,
  parameter int unsigned HOP              = 512,
  parameter int unsigned NUM_FFT          = 3,
  parameter int unsigned FRAMES_PER_BLOCK = 47,
  parameter int unsigned BLOCK_LEN        = 25000,
  localparam int unsigned ADDR_W          = cnt_width(FFT_LEN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      adc_input_valid,
  input  logic [DATA_W-1:0]         adc_data,
  input  logic [NUM_FFT-1:0]        buf_ready,
  output logic [NUM_FFT-1:0]        write_active,
  output logic [NUM_FFT*ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0]         sample_data,
  output logic [NUM_FFT-1:0]        frame_start,
  output logic [NUM_FFT-1:0]        frame_done,
  output logic                      block_start,
  output logic [NUM_FFT-1:0]        overrun
);

  localparam int unsigned BlkW = cnt_width(BLOCK_LEN);
  localparam int unsigned HopW = cnt_width(HOP);
  localparam int unsigned WinW = cnt_width(FRAMES_PER_BLOCK + 1);
  localparam int unsigned BufW = cnt_width(NUM_FFT);

  if (!sched_params_ok(FFT_LEN, HOP, NUM_FFT, FRAMES_PER_BLOCK, BLOCK_LEN)) begin : g_param_check
    $error("adc_frame_scheduler: inconsistent schedule parameters");
  end

  logic [BlkW-1:0]    r_blk_cnt;
  logic [HopW-1:0]    r_hop_cnt;
  logic [WinW-1:0]    r_win_idx;
  logic [BufW-1:0]    r_buf_idx;
  logic               w_win_start;
  logic               w_blk_wrap;
  logic [NUM_FFT-1:0] w_buf_start;

  // r_win_idx saturates at FRAMES_PER_BLOCK, which silences the tail of the block.
  assign w_win_start = (r_hop_cnt == '0) && (r_win_idx < WinW'(FRAMES_PER_BLOCK));
  assign w_blk_wrap  = (r_blk_cnt == BlkW'(BLOCK_LEN - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_blk_cnt   <= '0;
      r_hop_cnt   <= '0;
      r_win_idx   <= '0;
      r_buf_idx   <= '0;
      block_start <= 1'b0;
      sample_data <= '0;
    end else begin
      block_start <= adc_input_valid && (r_blk_cnt == '0);
      sample_data <= adc_input_valid ? adc_data : '0;
      if (adc_input_valid) begin
        if (w_blk_wrap) begin
          r_blk_cnt <= '0;
          r_hop_cnt <= '0;
          r_win_idx <= '0;
          r_buf_idx <= '0;
        end else begin
          r_blk_cnt <= BlkW'(r_blk_cnt + 1'b1);
          r_hop_cnt <= (r_hop_cnt == HopW'(HOP - 1)) ? '0 : HopW'(r_hop_cnt + 1'b1);
          if (w_win_start) begin
            r_win_idx <= WinW'(r_win_idx + 1'b1);
            r_buf_idx <= (r_buf_idx == BufW'(NUM_FFT - 1)) ? '0 : BufW'(r_buf_idx + 1'b1);
          end
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_FFT; b++) begin : g_buf
    assign w_buf_start[b] = w_win_start && (r_buf_idx == BufW'(b));

    fft_buffer_writer #(
      .FFT_LEN (FFT_LEN),
      .ADDR_W  (ADDR_W)
    ) u_writer (
      .clk            (clk),
      .reset          (reset),
      .i_valid        (adc_input_valid),
      .i_start        (w_buf_start[b]),
      .i_ready        (buf_ready[b]),
      .o_write_active (write_active[b]),
      .o_addr         (write_addr[b*ADDR_W +: ADDR_W]),
      .o_frame_start  (frame_start[b]),
      .o_frame_done   (frame_done[b]),
      .o_overrun      (overrun[b])
    );
  end

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Scoreboard bench for adc_frame_scheduler with default parameters: a window
// model queues expected responses, a negedge monitor compares them.
module tb_adc_frame_scheduler;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned FFT_LEN   = 1024;
  localparam int unsigned HOP       = 512;
  localparam int unsigned NUM_FFT   = 3;
  localparam int unsigned FRAMES    = 47;
  localparam int unsigned BLOCK_LEN = 25000;
  localparam int unsigned ADDR_W    = 10;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      adc_input_valid = 1'b0;
  logic [DATA_W-1:0]         adc_data = '0;
  logic [NUM_FFT-1:0]        buf_ready = '1;
  logic [NUM_FFT-1:0]        write_active;
  logic [NUM_FFT*ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0]         sample_data;
  logic [NUM_FFT-1:0]        frame_start;
  logic [NUM_FFT-1:0]        frame_done;
  logic                      block_start;
  logic [NUM_FFT-1:0]        overrun;

  always #5 clk = ~clk;

  adc_frame_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .adc_input_valid (adc_input_valid),
    .adc_data        (adc_data),
    .buf_ready       (buf_ready),
    .write_active    (write_active),
    .write_addr      (write_addr),
    .sample_data     (sample_data),
    .frame_start     (frame_start),
    .frame_done      (frame_done),
    .block_start     (block_start),
    .overrun         (overrun)
  );

  typedef struct {
    int                        blk;
    int                        c;
    logic [NUM_FFT-1:0]        wa;
    logic [NUM_FFT*ADDR_W-1:0] addr;
    logic [DATA_W-1:0]         data;
    logic [NUM_FFT-1:0]        fs;
    logic [NUM_FFT-1:0]        fd;
    logic                      bs;
    logic [NUM_FFT-1:0]        ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Window model state
  int                 m_c = 0;
  int                 m_blk = 0;
  bit                 win_ok[FRAMES];
  logic [NUM_FFT-1:0] m_ovr = '0;

  // Monitor-side tallies
  int fs_cnt0 = 0;
  int wr_cnt0 = 0;
  int buf1_early = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic send(input logic [NUM_FFT-1:0] rdy, input int gap);
    exp_t e;
    adc_input_valid = 1'b1;
    adc_data        = DATA_W'($urandom);
    buf_ready       = rdy;
    e.blk  = m_blk;
    e.c    = m_c;
    e.wa   = '0;
    e.addr = '0;
    e.fs   = '0;
    e.fd   = '0;
    e.bs   = (m_c == 0);
    e.data = adc_data;
    for (int k = 0; k < FRAMES; k++) begin
      int b;
      int s;
      b = k % NUM_FFT;
      s = k * HOP;
      if (m_c == s) begin
        win_ok[k] = rdy[b];
        if (!rdy[b]) m_ovr[b] = 1'b1;
      end
      if (m_c >= s && m_c < s + FFT_LEN && win_ok[k]) begin
        e.wa[b] = 1'b1;
        e.addr[b*ADDR_W +: ADDR_W] = ADDR_W'(m_c - s);
        if (m_c == s) e.fs[b] = 1'b1;
        if (m_c == s + FFT_LEN - 1) e.fd[b] = 1'b1;
      end
    end
    e.ovr = m_ovr;
    exp_q.push_back(e);
    m_c++;
    if (m_c == BLOCK_LEN) begin
      m_c = 0;
      m_blk++;
    end
    @(posedge clk);
    #1;
    adc_input_valid = 1'b0;
    buf_ready       = '1;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset is held for two edges; an optional strobe in the first must be ignored.
  task automatic do_reset(input bit with_strobe);
    reset           = 1'b0;
    adc_input_valid = with_strobe;
    adc_data        = 12'hABC;
    @(posedge clk);
    #1;
    adc_input_valid = 1'b0;
    check("reset_overrun", overrun, 0);
    check("reset_write_active", write_active, 0);
    check("reset_block_start", block_start, 0);
    check("reset_sample_data", sample_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_c   = 0;
    m_ovr = '0;
    m_blk++;
  endtask

  logic               tb_strobe_q = 1'b0;
  logic               tb_rst_q = 1'b0;
  logic [NUM_FFT-1:0] cur_ovr = '0;
  exp_t               mon_e;

  always @(posedge clk) begin
    tb_strobe_q <= adc_input_valid && reset;
    tb_rst_q    <= !reset;
  end

  always @(negedge clk) begin
    if (tb_strobe_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        cur_ovr = mon_e.ovr;
        check("write_active", write_active, mon_e.wa);
        check("write_addr", write_addr, mon_e.addr);
        check("sample_data", sample_data, mon_e.data);
        check("frame_start", frame_start, mon_e.fs);
        check("frame_done", frame_done, mon_e.fd);
        check("block_start", block_start, mon_e.bs);
        check("overrun", overrun, mon_e.ovr);
        if (mon_e.blk == 0) begin
          fs_cnt0 += $countones(frame_start);
          wr_cnt0 += $countones(write_active);
          if (mon_e.c == 0) check("blk0_c0_block_start", block_start, 1);
          if (mon_e.c == 600) begin
            check("blk0_c600_active", write_active, 3'b011);
            check("blk0_c600_addr0", write_addr[ADDR_W-1:0], 600);
            check("blk0_c600_addr1", write_addr[2*ADDR_W-1:ADDR_W], 88);
          end
          if (mon_e.c == 1023) check("blk0_c1023_done", frame_done, 3'b001);
          if (mon_e.c == 1024) check("blk0_c1024_start", frame_start, 3'b100);
          if (mon_e.c == 24576) check("blk0_c24576_idle", write_active, 0);
        end
        if (mon_e.blk == 1) begin
          if (mon_e.c < 2048) buf1_early += int'(write_active[1]);
          if (mon_e.c == 0) check("blk1_c0_block_start", block_start, 1);
          if (mon_e.c == 512) check("blk1_c512_overrun", overrun, 3'b010);
          if (mon_e.c == 600) check("blk1_c600_active", write_active, 3'b001);
          if (mon_e.c == 2048) check("blk1_c2048_start", frame_start, 3'b010);
        end
        if (mon_e.blk == 2 && mon_e.c == 700) check("blk2_c700_overrun", overrun, 3'b010);
        if (mon_e.blk == 3 && mon_e.c == 0) begin
          check("blk3_c0_block_start", block_start, 1);
          check("blk3_c0_frame_start", frame_start, 3'b001);
        end
      end
    end else begin
      if (tb_rst_q) cur_ovr = '0;
      check("idle_outputs", {write_active, write_addr, sample_data, frame_start, frame_done,
                             block_start}, 0);
      check("idle_overrun", overrun, cur_ovr);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("por_overrun", overrun, 0);
    check("por_write_active", write_active, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Block 0: all buffers ready, gapped strobes at first then back-to-back.
    for (int i = 0; i < BLOCK_LEN; i++) send(3'b111, (i < 300) ? $urandom_range(20, 1) : 0);

    // Block 1: buffer 1 not ready at window 1 start.
    for (int i = 0; i < 2101; i++) send((i == 512) ? 3'b101 : 3'b111, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b1);

    // Block 2: drop again, then reset mid-window right after sample 700.
    for (int i = 0; i < 701; i++) send((i == 512) ? 3'b101 : 3'b111, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Block 3: restart from sample 0.
    for (int i = 0; i < 5; i++) send(3'b111, 1);
    repeat (3) @(posedge clk);
    #1;

    check("blk0_frame_starts", fs_cnt0, 47);
    check("blk0_total_writes", wr_cnt0, 47 * 1024);
    check("blk1_buf1_no_early_writes", buf1_early, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
